// File: rtl/fpu_issue_if.sv
// ID-stage <-> FPU issue bundle: request, FPU pipeline status, issue command.
// master drives the request/status side, slave is fpu_issue_ctrl.
interface fpu_issue_if #(
  parameter int DW = 32
);
  logic          id_fpop;
  logic [2:0]    id_fc;
  logic          id_wf;
  logic [4:0]    id_fs;
  logic [4:0]    id_ft;
  logic [4:0]    id_fd;
  logic          ext_stall;
  logic [4:0]    e1n, e2n, e3n, wn;
  logic          e1w, e2w, e3w, ww;
  logic [DW-1:0] ed;
  logic [DW-1:0] wd;
  logic          st_ds;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [4:0]    fd;
  logic [2:0]    fc;
  logic          wf;
  logic          ein1;
  logic          ein2;
  logic          stall_id;

  modport master (
    output id_fpop, id_fc, id_wf, id_fs, id_ft, id_fd,
    output ext_stall, e1n, e2n, e3n, wn,
    output e1w, e2w, e3w, ww, ed, wd, st_ds,
    input  a, b, fd, fc, wf, ein1, ein2, stall_id
  );

  modport slave (
    input  id_fpop, id_fc, id_wf, id_fs, id_ft, id_fd,
    input  ext_stall, e1n, e2n, e3n, wn,
    input  e1w, e2w, e3w, ww, ed, wd, st_ds,
    output a, b, fd, fc, wf, ein1, ein2, stall_id
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// FPU issue control: FP regfile, E3/W forwarding, E1/E2 RAW stall, div/sqrt FSM.
// Define FPU_STALL_CNT_EN to add the stall_cnt stall-cycle counter port.
module fpu_issue_ctrl #(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic        clk,
  input  logic        clrn,
`ifdef FPU_STALL_CNT_EN
  output logic [31:0] stall_cnt,
`endif
  fpu_issue_if.slave  io
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  logic [DW-1:0] rf [NREG];
  logic [DW-1:0] opd_s;
  logic [DW-1:0] opd_t;
  logic          haz_s;
  logic          haz_t;
  logic          ft_chk;
  logic          raw;
  state_t        state;
  state_t        state_n;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else if (io.ww) begin
      rf[io.wn] <= io.wd;
    end
  end

  // E1/E2 results are not ready yet; E3 and W can be forwarded.
  always_comb begin
    haz_s = 1'b0;
    opd_s = rf[io.id_fs];
    if (io.e1w && io.e1n == io.id_fs) begin
      haz_s = 1'b1;
    end else if (io.e2w && io.e2n == io.id_fs) begin
      haz_s = 1'b1;
    end else if (io.e3w && io.e3n == io.id_fs) begin
      opd_s = io.ed;
    end else if (io.ww && io.wn == io.id_fs) begin
      opd_s = io.wd;
    end
  end

  always_comb begin
    haz_t = 1'b0;
    opd_t = rf[io.id_ft];
    if (io.e1w && io.e1n == io.id_ft) begin
      haz_t = 1'b1;
    end else if (io.e2w && io.e2n == io.id_ft) begin
      haz_t = 1'b1;
    end else if (io.e3w && io.e3n == io.id_ft) begin
      opd_t = io.ed;
    end else if (io.ww && io.wn == io.id_ft) begin
      opd_t = io.wd;
    end
  end

  assign ft_chk = (io.id_fc[2:1] != 2'b11);
  assign raw    = io.id_fpop & (haz_s | (haz_t & ft_chk));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    if (!io.ext_stall) begin
      unique case (state)
        IDLE:    if (io.st_ds) state_n = WAIT;
        WAIT:    if (!io.st_ds) state_n = DRAIN;
        DRAIN:   state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // WAIT masks short st_ds dips; DRAIN ignores st_ds entirely.
  always_comb begin
    io.a     = opd_s;
    io.b     = opd_t;
    io.fd    = io.id_fd;
    io.fc    = io.id_fc;
    io.wf    = io.id_wf & io.id_fpop;
    io.ein1  = ~io.ext_stall;
    io.ein2  = ~raw;
    unique case (state)
      WAIT:    io.stall_id = 1'b1;
      DRAIN:   io.stall_id = raw | io.ext_stall;
      default: io.stall_id = raw | io.st_ds | io.ext_stall;
    endcase
  end

`ifdef FPU_STALL_CNT_EN
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stall_cnt <= '0;
    end else if (!io.ext_stall && (raw || io.st_ds)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
